// File: rtl/tetris_param.sv
// -----------------------------------------------------------------------------
// tetris_param
//
// Purpose:
//   Drops one tetromino per accepted handshake onto a COLS x ROWS board.
//   The board is kept with four hidden rows on top. Full visible rows are
//   removed one per cycle, and a single-cycle report is produced per piece.
//   A game ends on overflow or an out-of-range footprint, or after ROUNDS
//   pieces. The board, score and piece count are then cleared for a new game.
//
// Ports:
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   in_valid     : a piece is offered this cycle
//   in_ready     : high only while waiting for a piece
//   tetrominoes  : piece id 0..7
//   position     : leftmost column of the piece footprint
//   tetris_valid : high for the single report cycle of each piece
//   score_valid  : identical to tetris_valid
//   fail         : game lost on this piece (valid with tetris_valid)
//   score        : cumulative lines cleared in the current game
//   tetris       : visible board, bit r*COLS+c = row r (0 = bottom), column c
//
// Every output comes straight from a flop. tetris, score and fail are zero
// outside the report cycle.
// -----------------------------------------------------------------------------
module tetris_param #(
    parameter int COLS    = 6,
    parameter int ROWS    = 12,
    parameter int ROUNDS  = 16,
    parameter int SCORE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              tetrominoes,
    input  logic [$clog2(COLS)-1:0] position,
    output logic                    tetris_valid,
    output logic                    score_valid,
    output logic                    fail,
    output logic [SCORE_W-1:0]      score,
    output logic [COLS*ROWS-1:0]    tetris
);

    localparam int BROWS = ROWS + 4;
    localparam int CNT_W = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {
        READY  = 2'd0,
        CLEAR  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                          state_q, state_d;
    logic [BROWS-1:0][COLS-1:0]      board_q, board_d;
    logic [SCORE_W-1:0]              score_q, score_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic                            oob_q, oob_d;
    logic                            in_ready_q, in_ready_d;
    logic                            rep_valid_q, rep_valid_d;
    logic                            rep_fail_q, rep_fail_d;
    logic [SCORE_W-1:0]              rep_score_q, rep_score_d;
    logic [COLS*ROWS-1:0]            rep_tetris_q, rep_tetris_d;

    // ------------------------------------------------------------------
    // Piece footprint decode: four (dx,dy) cells and the footprint width
    // ------------------------------------------------------------------
    int cell_dx [4];
    int cell_dy [4];
    int piece_w;

    always_comb begin
        cell_dx = '{0, 0, 0, 0};
        cell_dy = '{0, 0, 0, 0};
        piece_w = 1;
        case (tetrominoes)
            3'd0: begin cell_dx = '{0, 1, 0, 1}; cell_dy = '{0, 0, 1, 1}; piece_w = 2; end
            3'd1: begin cell_dx = '{0, 0, 0, 0}; cell_dy = '{0, 1, 2, 3}; piece_w = 1; end
            3'd2: begin cell_dx = '{0, 1, 2, 3}; cell_dy = '{0, 0, 0, 0}; piece_w = 4; end
            3'd3: begin cell_dx = '{1, 1, 0, 1}; cell_dy = '{0, 1, 2, 2}; piece_w = 2; end
            3'd4: begin cell_dx = '{0, 0, 1, 2}; cell_dy = '{0, 1, 1, 1}; piece_w = 3; end
            3'd5: begin cell_dx = '{0, 1, 0, 0}; cell_dy = '{0, 0, 1, 2}; piece_w = 2; end
            3'd6: begin cell_dx = '{1, 0, 1, 0}; cell_dy = '{0, 1, 1, 2}; piece_w = 2; end
            default: begin cell_dx = '{0, 1, 1, 2}; cell_dy = '{0, 0, 1, 1}; piece_w = 3; end
        endcase
    end

    // A footprint reaching past the last column is a lost game, not a clip.
    logic placement_oob;
    assign placement_oob = (int'(position) + piece_w) > COLS;

    // ------------------------------------------------------------------
    // Column heights (1 + index of topmost filled cell, 0 when empty)
    // ------------------------------------------------------------------
    int col_h [COLS];

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_h[c] = 0;
            for (int r = 0; r < BROWS; r++) begin
                if (board_q[r][c]) begin
                    col_h[c] = r + 1;
                end
            end
        end
    end

    // Landing row: the lowest row at which no cell of the piece overlaps
    // the stack. Taking the max of (height - dy) over all cells is the same
    // as using only the lowest dy of each column.
    int land_row;

    always_comb begin
        land_row = 0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < COLS; c++) begin
                if ((int'(position) + cell_dx[k] == c) &&
                    (col_h[c] - cell_dy[k] > land_row)) begin
                    land_row = col_h[c] - cell_dy[k];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Board with the piece dropped in. While a game is running, the stack
    // never exceeds ROWS rows (otherwise it would already have failed), so
    // landing + 3 always fits inside the four hidden rows.
    // ------------------------------------------------------------------
    logic [BROWS-1:0][COLS-1:0] placed;

    for (genvar gi = 0; gi < BROWS; gi++) begin : g_place
        logic [COLS-1:0] add_row;
        always_comb begin
            add_row = '0;
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < COLS; c++) begin
                    if ((int'(position) + cell_dx[k] == c) &&
                        (land_row + cell_dy[k] == gi)) begin
                        add_row[c] = 1'b1;
                    end
                end
            end
        end
        assign placed[gi] = board_q[gi] | add_row;
    end

    // ------------------------------------------------------------------
    // Lowest full visible row removal
    // ------------------------------------------------------------------
    logic [ROWS-1:0]            row_full;
    logic [ROWS-1:0]            full_upto;   // some full row at or below r
    logic [BROWS-1:0]           shift_en;    // row takes the row above it
    logic [BROWS-1:0][COLS-1:0] cleared;
    logic                       any_full;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_full
        assign row_full[gi]  = &board_q[gi];
        assign full_upto[gi] = |row_full[gi:0];
    end
    assign any_full = full_upto[ROWS-1];

    for (genvar gi = 0; gi < BROWS; gi++) begin : g_shift
        if (gi < ROWS) begin : g_vis
            assign shift_en[gi] = full_upto[gi];
        end else begin : g_hid
            assign shift_en[gi] = any_full;
        end
        if (gi == BROWS - 1) begin : g_top
            assign cleared[gi] = shift_en[gi] ? '0 : board_q[gi];
        end else begin : g_mid
            assign cleared[gi] = shift_en[gi] ? board_q[gi+1] : board_q[gi];
        end
    end

    // ------------------------------------------------------------------
    // Visible snapshot and overflow detection
    // ------------------------------------------------------------------
    logic [COLS*ROWS-1:0] vis;
    logic [3:0]           ovf_bits;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_vis_flat
        assign vis[gi*COLS +: COLS] = board_q[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ovf
        assign ovf_bits[gi] = |board_q[ROWS+gi];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        score_d      = score_q;
        count_d      = count_q;
        oob_d        = oob_q;
        rep_valid_d  = 1'b0;
        rep_fail_d   = 1'b0;
        rep_score_d  = '0;
        rep_tetris_d = '0;

        case (state_q)
            READY: begin
                if (in_valid) begin
                    count_d = count_q + CNT_W'(1);
                    oob_d   = placement_oob;
                    if (!placement_oob) begin
                        board_d = placed;
                    end
                    state_d = CLEAR;
                end
            end

            CLEAR: begin
                // An out-of-range piece left the board untouched, so there
                // is nothing to remove and it goes straight to the report.
                if (any_full && !oob_q) begin
                    board_d = cleared;
                    if (score_q != {SCORE_W{1'b1}}) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else begin
                    state_d      = REPORT;
                    rep_valid_d  = 1'b1;
                    rep_tetris_d = vis;
                    rep_score_d  = score_q;
                    rep_fail_d   = oob_q | (|ovf_bits);
                end
            end

            REPORT: begin
                state_d = READY;
                oob_d   = 1'b0;
                if (rep_fail_q || (count_q == CNT_W'(ROUNDS))) begin
                    board_d = '0;
                    score_d = '0;
                    count_d = '0;
                end
            end

            default: begin
                state_d = READY;
            end
        endcase

        in_ready_d = (state_d == READY);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= READY;
            board_q      <= '0;
            score_q      <= '0;
            count_q      <= '0;
            oob_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            rep_valid_q  <= 1'b0;
            rep_fail_q   <= 1'b0;
            rep_score_q  <= '0;
            rep_tetris_q <= '0;
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            score_q      <= score_d;
            count_q      <= count_d;
            oob_q        <= oob_d;
            in_ready_q   <= in_ready_d;
            rep_valid_q  <= rep_valid_d;
            rep_fail_q   <= rep_fail_d;
            rep_score_q  <= rep_score_d;
            rep_tetris_q <= rep_tetris_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign tetris_valid = rep_valid_q;
    assign score_valid  = rep_valid_q;
    assign fail         = rep_fail_q;
    assign score        = rep_score_q;
    assign tetris       = rep_tetris_q;

endmodule

// File: tb/tb_tetris_param.sv
// -----------------------------------------------------------------------------
// tb_tetris_param
//
// Self-checking bench for tetris_param (default 6x12 board, 16 rounds).
// A reference model holds the board as a 2-D bit array. It drops each piece
// by column heights and removes full rows. It predicts the report latency,
// the board, the score and fail for each piece.
// -----------------------------------------------------------------------------
module tb_tetris_param;

    localparam int COLS   = 6;
    localparam int ROWS   = 12;
    localparam int ROUNDS = 16;
    localparam int SW     = 8;
    localparam int PW     = $clog2(COLS);
    localparam int TW     = COLS * ROWS;
    localparam int BR     = ROWS + 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    tetrominoes = '0;
    logic [PW-1:0] position = '0;
    logic          in_ready, tetris_valid, score_valid, fail;
    logic [SW-1:0] score;
    logic [TW-1:0] tetris;

    always #5 clk = ~clk;

    tetris_param #(.COLS(COLS), .ROWS(ROWS), .ROUNDS(ROUNDS), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .tetrominoes(tetrominoes), .position(position),
        .tetris_valid(tetris_valid), .score_valid(score_valid), .fail(fail),
        .score(score), .tetris(tetris)
    );

    int n_vec = 0;
    int n_err = 0;

    // Footprint table, cells as (dx,dy) with dy counted up from the landing row.
    int pdx [8][4] = '{'{0,1,0,1}, '{0,0,0,0}, '{0,1,2,3}, '{1,1,0,1},
                       '{0,0,1,2}, '{0,1,0,0}, '{1,0,1,0}, '{0,1,1,2}};
    int pdy [8][4] = '{'{0,0,1,1}, '{0,1,2,3}, '{0,0,0,0}, '{0,1,2,2},
                       '{0,1,1,1}, '{0,0,1,2}, '{0,1,1,2}, '{0,0,1,1}};

    // Reference model state and predictions
    bit            mb [BR][COLS];
    int            m_score, m_count;
    int            e_k, e_s;
    bit            e_f;
    logic [TW-1:0] e_t;

    // Observations from the last applied piece
    int            lat, anom;
    logic [TW-1:0] o_t;
    logic [SW-1:0] o_s;
    logic          o_f, o_sv, nx_rdy;

    task automatic model_reset();
        for (int r = 0; r < BR; r++) for (int c = 0; c < COLS; c++) mb[r][c] = 1'b0;
        m_score = 0;
        m_count = 0;
    endtask

    task automatic model_piece(input int p, input int pos);
        int h [COLS];
        int w, land, fr;
        bit all;
        e_k = 0; e_f = 1'b0; w = 0;
        for (int i = 0; i < 4; i++) if (pdx[p][i] + 1 > w) w = pdx[p][i] + 1;
        if (pos + w > COLS) begin
            e_f = 1'b1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                h[c] = 0;
                for (int r = 0; r < BR; r++) if (mb[r][c]) h[c] = r + 1;
            end
            land = 0;
            for (int i = 0; i < 4; i++)
                if (h[pos+pdx[p][i]] - pdy[p][i] > land) land = h[pos+pdx[p][i]] - pdy[p][i];
            for (int i = 0; i < 4; i++)
                if (land + pdy[p][i] < BR) mb[land+pdy[p][i]][pos+pdx[p][i]] = 1'b1;
            fr = 0;
            while (fr >= 0) begin
                fr = -1;
                for (int r = ROWS - 1; r >= 0; r--) begin
                    all = 1'b1;
                    for (int c = 0; c < COLS; c++) if (!mb[r][c]) all = 1'b0;
                    if (all) fr = r;
                end
                if (fr >= 0) begin
                    for (int r = fr; r < BR - 1; r++) mb[r] = mb[r+1];
                    for (int c = 0; c < COLS; c++) mb[BR-1][c] = 1'b0;
                    e_k++;
                    if (m_score < (1 << SW) - 1) m_score++;
                end
            end
            for (int r = ROWS; r < BR; r++) for (int c = 0; c < COLS; c++) if (mb[r][c]) e_f = 1'b1;
        end
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) e_t[r*COLS+c] = mb[r][c];
        e_s = m_score;
        m_count++;
        if (e_f || m_count == ROUNDS) model_reset();
    endtask

    // Drives one piece and captures the report and the cycle after it.
    // anom counts cycles where in_ready or a data output was wrongly active.
    task automatic apply_piece(input int p, input int pos, input bit noise);
        anom = 0; lat = -1; o_t = '0; o_s = '0; o_f = 1'b0; o_sv = 1'b0;
        for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
        in_valid = 1'b1; tetrominoes = 3'(p); position = PW'(pos);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (tetris_valid) begin
                lat = j; o_t = tetris; o_s = score; o_f = fail; o_sv = score_valid;
                break;
            end
            if (in_ready || score_valid || fail || score != '0 || tetris != '0) anom++;
            if (noise) begin
                in_valid    = 1'($urandom_range(0, 1));
                tetrominoes = 3'($urandom);
                position    = PW'($urandom_range(0, COLS - 1));
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        nx_rdy = in_ready;
        if (tetris_valid || tetris != '0 || score != '0 || fail) anom++;
    endtask

    task automatic rst_pulse();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if ({tetris_valid, score_valid, fail} !== 3'b000 || score !== '0 || tetris !== '0) begin
            n_err++; $display("FAIL reset_outputs: got v=%b sv=%b f=%b s=%0d t=%h want all 0", tetris_valid, score_valid, fail, score, tetris); end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_vec++; if (tetris_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", tetris_valid); end
        model_reset();
    endtask

    task automatic test_first_piece();
        model_piece(2, 0);
        apply_piece(2, 0, 1'b0);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL first_latency: got %0d want 2", lat); end
        n_vec++; if (o_t !== 72'hF) begin n_err++; $display("FAIL first_board: got %h want %h", o_t, 72'hF); end
        n_vec++; if (o_s !== 8'd0 || o_f !== 1'b0 || o_sv !== 1'b1) begin
            n_err++; $display("FAIL first_score: got s=%0d f=%b sv=%b want s=0 f=0 sv=1", o_s, o_f, o_sv); end
    endtask

    task automatic test_line_clear();
        model_piece(0, 4);
        apply_piece(0, 4, 1'b0);
        n_vec++; if (lat !== 3) begin n_err++; $display("FAIL clear1_latency: got %0d want 3", lat); end
        n_vec++; if (o_t !== 72'h30) begin n_err++; $display("FAIL clear1_board: got %h want %h", o_t, 72'h30); end
        n_vec++; if (o_s !== 8'd1 || o_f !== 1'b0) begin n_err++; $display("FAIL clear1_score: got s=%0d f=%b want s=1 f=0", o_s, o_f); end
        n_vec++; if (nx_rdy !== 1'b1 || anom !== 0) begin n_err++; $display("FAIL clear1_handshake: got rdy=%b anom=%0d want rdy=1 anom=0", nx_rdy, anom); end
    endtask

    task automatic test_quad_clear();
        int ps [5] = '{2, 2, 2, 2, 1};
        int xs [5] = '{0, 0, 0, 0, 4};
        rst_pulse();
        for (int i = 0; i < 5; i++) begin
            model_piece(ps[i], xs[i]);
            apply_piece(ps[i], xs[i], 1'b0);
            n_vec++; if (lat !== 2 + e_k || o_t !== e_t) begin
                n_err++; $display("FAIL quad_prefill%0d: got lat=%0d t=%h want lat=%0d t=%h", i, lat, o_t, 2 + e_k, e_t); end
        end
        model_piece(1, 5);
        apply_piece(1, 5, 1'b1);
        n_vec++; if (lat !== 6) begin n_err++; $display("FAIL quad_latency: got %0d want 6", lat); end
        n_vec++; if (o_t !== '0 || o_s !== 8'd4 || o_f !== 1'b0) begin
            n_err++; $display("FAIL quad_result: got t=%h s=%0d f=%b want t=0 s=4 f=0", o_t, o_s, o_f); end
        n_vec++; if (anom !== 0 || nx_rdy !== 1'b1) begin n_err++; $display("FAIL quad_busy: got anom=%0d rdy=%b want 0/1", anom, nx_rdy); end
    endtask

    task automatic test_stack_fail();
        rst_pulse();
        for (int i = 0; i < 4; i++) begin
            model_piece(1, 0);
            apply_piece(1, 0, 1'b0);
            n_vec++; if (lat !== 2 || o_f !== e_f || o_t !== e_t) begin
                n_err++; $display("FAIL stack%0d: got lat=%0d f=%b t=%h want lat=2 f=%b t=%h", i, lat, o_f, o_t, e_f, e_t); end
        end
        n_vec++; if (o_f !== 1'b1 || nx_rdy !== 1'b1) begin n_err++; $display("FAIL stack_fail: got f=%b rdy=%b want 1/1", o_f, nx_rdy); end
        model_piece(2, 0);
        apply_piece(2, 0, 1'b0);
        n_vec++; if (o_t !== 72'hF || o_s !== 8'd0) begin n_err++; $display("FAIL stack_newgame: got t=%h s=%0d want t=f s=0", o_t, o_s); end
    endtask

    task automatic test_out_of_range();
        rst_pulse();
        model_piece(0, 0);
        apply_piece(0, 0, 1'b0);
        model_piece(2, 3);
        apply_piece(2, 3, 1'b0);
        n_vec++; if (lat !== 2 || o_f !== 1'b1) begin n_err++; $display("FAIL oob_report: got lat=%0d f=%b want 2/1", lat, o_f); end
        n_vec++; if (o_t !== 72'hC3 || o_s !== 8'd0) begin n_err++; $display("FAIL oob_board: got t=%h s=%0d want t=c3 s=0", o_t, o_s); end
        model_piece(2, 0);
        apply_piece(2, 0, 1'b0);
        n_vec++; if (o_t !== 72'hF || o_f !== 1'b0) begin n_err++; $display("FAIL oob_restart: got t=%h f=%b want t=f f=0", o_t, o_f); end
    endtask

    task automatic test_rounds();
        int p, x;
        rst_pulse();
        for (int i = 0; i < ROUNDS + 1; i++) begin
            p = (i % 2 == 0) ? 2 : 0;
            x = (i % 2 == 0) ? 0 : 4;
            model_piece(p, x);
            apply_piece(p, x, 1'b0);
            n_vec++; if (lat !== 2 + e_k || o_t !== e_t || o_s !== SW'(e_s) || o_f !== e_f) begin
                n_err++; $display("FAIL rounds%0d: got lat=%0d t=%h s=%0d f=%b want lat=%0d t=%h s=%0d f=%b",
                                  i, lat, o_t, o_s, o_f, 2 + e_k, e_t, e_s, e_f); end
            if (i == ROUNDS - 1) begin
                n_vec++; if (o_s !== 8'd8) begin n_err++; $display("FAIL rounds_last_score: got %0d want 8", o_s); end
            end
        end
        n_vec++; if (o_t !== 72'hF || o_s !== 8'd0) begin n_err++; $display("FAIL rounds_newgame: got t=%h s=%0d want t=f s=0", o_t, o_s); end
    endtask

    task automatic test_reset_mid_clear();
        rst_pulse();
        model_piece(2, 0);
        apply_piece(2, 0, 1'b0);
        in_valid = 1'b1; tetrominoes = 3'd0; position = PW'(4);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if ({tetris_valid, score_valid, fail} !== 3'b000 || score !== '0 || tetris !== '0) begin
            n_err++; $display("FAIL midclear_outputs: got v=%b f=%b s=%0d t=%h want 0", tetris_valid, fail, score, tetris); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        model_reset();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midclear_ready: got %b want 1", in_ready); end
        model_piece(0, 4);
        apply_piece(0, 4, 1'b0);
        n_vec++; if (lat !== 2 || o_t !== 72'hC30 || o_s !== 8'd0) begin
            n_err++; $display("FAIL midclear_after: got lat=%0d t=%h s=%0d want 2/c30/0", lat, o_t, o_s); end
        // Reset asserted in the report cycle must drop the outputs at once.
        in_valid = 1'b1; tetrominoes = 3'd1; position = PW'(0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 10 && !tetris_valid; j++) @(negedge clk);
        n_vec++; if (tetris_valid !== 1'b1) begin n_err++; $display("FAIL report_seen: got %b want 1", tetris_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (tetris_valid !== 1'b0 || score_valid !== 1'b0 || tetris !== '0) begin
            n_err++; $display("FAIL async_reset: got v=%b sv=%b t=%h want 0", tetris_valid, score_valid, tetris); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_random();
        int p, x;
        rst_pulse();
        for (int i = 0; i < 150; i++) begin
            p = $urandom_range(0, 7);
            x = $urandom_range(0, COLS - 1);
            model_piece(p, x);
            apply_piece(p, x, 1'($urandom_range(0, 1)));
            n_vec++; if (lat !== 2 + e_k) begin n_err++; $display("FAIL rand%0d_latency: p=%0d x=%0d got %0d want %0d", i, p, x, lat, 2 + e_k); end
            n_vec++; if (o_t !== e_t) begin n_err++; $display("FAIL rand%0d_board: p=%0d x=%0d got %h want %h", i, p, x, o_t, e_t); end
            n_vec++; if (o_s !== SW'(e_s) || o_f !== e_f || o_sv !== 1'b1) begin
                n_err++; $display("FAIL rand%0d_score: got s=%0d f=%b sv=%b want s=%0d f=%b sv=1", i, o_s, o_f, o_sv, e_s, e_f); end
            n_vec++; if (anom !== 0 || nx_rdy !== 1'b1) begin n_err++; $display("FAIL rand%0d_handshake: got anom=%0d rdy=%b want 0/1", i, anom, nx_rdy); end
        end
    endtask

    initial begin
        test_reset();
        test_first_piece();
        test_line_clear();
        test_quad_clear();
        test_stack_fail();
        test_out_of_range();
        test_rounds();
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tetris_param.md
TETRIS_PARAM -- requirements
Module: tetris_param

Interface
REQ-001 SHALL have parameter COLS, default 6, meaning board width in columns (legal range 4..16).
REQ-002 SHALL have parameter ROWS, default 12, meaning visible board height in rows (legal range 4..16).
REQ-003 SHALL have parameter ROUNDS, default 16, meaning pieces per game.
REQ-004 SHALL have parameter SCORE_W, default 8, meaning score counter width.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit, piece offered this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts a piece this cycle.
REQ-009 SHALL have port tetrominoes, input, 3 bits, piece id 0..7.
REQ-010 SHALL have port position, input, $clog2(COLS) bits, leftmost column of the piece footprint.
REQ-011 SHALL have port tetris_valid, output, 1 bit, board output valid.
REQ-012 SHALL have port score_valid, output, 1 bit, score/fail output valid (always equal to tetris_valid).
REQ-013 SHALL have port fail, output, 1 bit, game lost on this piece.
REQ-014 SHALL have port score, output, SCORE_W bits, cumulative lines cleared in the current game.
REQ-015 SHALL have port tetris, output, COLS*ROWS bits, board snapshot; bit r*COLS+c = row r (0 = bottom), column c.

Function
REQ-016 SHALL implement states READY, CLEAR, REPORT; reset state READY.
REQ-017 SHALL drive in_ready=1 only in READY; a piece is accepted on in_valid & in_ready; in_valid outside READY is ignored.
REQ-018 SHALL use piece footprints as (dx,dy) cells, dy up from landing row: 0:(0,0)(1,0)(0,1)(1,1); 1:(0,0)(0,1)(0,2)(0,3); 2:(0,0)(1,0)(2,0)(3,0); 3:(1,0)(1,1)(0,2)(1,2); 4:(0,0)(0,1)(1,1)(2,1); 5:(0,0)(1,0)(0,1)(0,2); 6:(1,0)(0,1)(1,1)(0,2); 7:(0,0)(1,0)(1,1)(2,1).
REQ-019 SHALL compute landing row = max over occupied columns of (column height - lowest dy in that column), where column height = 1 + index of topmost filled cell, 0 if empty; cells land in an internal ROWS+4 row board.
REQ-020 SHALL, on acceptance, write the piece into the board and go to CLEAR next cycle.
REQ-021 SHALL, in each CLEAR cycle, remove the lowest full visible row (shift all rows above down by one, top row 0), increment score by 1 saturating at 2^SCORE_W-1, and stay in CLEAR; if no visible row is full, go to REPORT.
REQ-022 SHALL handle any number of simultaneous full rows (1..4) at one row per cycle; REPORT is entered at acceptance cycle T + 2 + k for k cleared rows.
REQ-023 SHALL assert tetris_valid=score_valid=1 for exactly the single REPORT cycle, with tetris=visible board, score=cumulative score, fail=1 iff any overflow row (>= ROWS) is nonzero.
REQ-024 SHALL treat a footprint extending past column COLS-1 as fail: board unchanged, no clear, REPORT at T+2 with fail=1.
REQ-025 SHALL count accepted pieces; after REPORT, if fail=1 or the count equals ROUNDS, clear board, score and count to 0 (new game), then go to READY.
REQ-026 SHALL drive tetris, score, fail to 0 whenever tetris_valid=0.
REQ-027 SHALL keep all outputs registered (no combinational path from inputs to outputs).

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-CLEAR, immediately set state READY, board 0, score 0, piece count 0, in_ready=1 after release, all other outputs 0.

Verification
REQ-029 Reset, then piece 2 at position 0 into empty 6x12 board -> REPORT at T+2, tetris bits 0..3 set, score 0, fail 0.
REQ-030 Pieces 2@0 then 0@4 -> second REPORT at T+3, row 0 cleared, tetris bits 4,5 set only (row 0 cols 4,5 from upper O half), score 1.
REQ-031 Rows 0..3 pre-filled except column 5, then piece 1@5 -> four CLEAR removals, REPORT at T+6, board empty, score 4; in_valid during CLEAR ignored.
REQ-032 Stack piece 1 at position 0 three times, fourth 1@0 -> fourth REPORT fail=1, next cycle in_ready=1 with board and score 0.
REQ-033 Piece 2 at position 3 (COLS=6) -> fail=1 at T+2, board unchanged, game restarts.
REQ-034 ROUNDS=16 non-failing pieces -> 16th REPORT followed by board/score reset; assert rst_n low during CLEAR -> all outputs 0 immediately.
